// File: rtl/lab3_stream_decoder.sv
// lab3_stream_decoder: recovers c = ~(x ^ (a|b)) per sample, packs LSB-first words, flags y != a^b
module lab3_stream_decoder #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             x,
  input  logic             y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [ERRW-1:0]  err_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d, word;
  logic sticky_q, sticky_d, err_q, err_d, c, e, in_xfer;
  logic [ERRW-1:0] err_cnt_q, err_cnt_d;
  assign in_ready  = (state_q == COLLECT) & ~flush;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign err_cnt   = err_cnt_q;
  assign c       = ~(x ^ (a | b));
  assign e       = y ^ (a ^ b);
  assign in_xfer = in_valid & in_ready;
  assign word    = shift_q | ({{(WIDTH-1){1'b0}}, c} << cnt_q);
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sticky_d  = sticky_q;
    data_d    = data_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (state_q == HOLD) begin
      if (out_ready) begin
        state_d   = COLLECT;
        err_cnt_d = (err_q && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
      end
    end else if (flush) begin
      cnt_d    = '0;
      shift_d  = '0;
      sticky_d = 1'b0;
    end else if (in_xfer) begin
      // Last bit: hand the completed word to the output register and start fresh
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d  = HOLD;
        data_d   = word;
        err_d    = sticky_q | e;
        cnt_d    = '0;
        shift_d  = '0;
        sticky_d = 1'b0;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        shift_d  = word;
        sticky_d = sticky_q | e;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      cnt_q     <= '0;
      shift_q   <= '0;
      sticky_q  <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sticky_q  <= sticky_d;
      data_q    <= data_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_lab3_stream_decoder.sv
// tb_lab3_stream_decoder: random and directed stimulus checked against a queue-based word model
module tb_lab3_stream_decoder;
  localparam int W = 8;
  localparam int EW = 2;
  localparam int EMAX = (1 << EW) - 1;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, a = 0, b = 0, x = 0, y = 0, out_ready = 0;
  logic in_ready, out_valid, out_err;
  logic [W-1:0] out_data;
  logic [EW-1:0] err_cnt;
  int n_vec = 0, n_bad = 0;

  lab3_stream_decoder #(.WIDTH(W), .ERRW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  bit mq[$];
  bit m_sticky, m_pend, m_err, m_known;
  logic [W-1:0] m_data;
  int m_cnt;

  task automatic chk(input string n, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference: collect recovered bits in a queue; a full queue becomes the pending word
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); m_sticky = 0; m_pend = 0; m_err = 0; m_data = '0; m_cnt = 0; m_known = 1;
    end else if (m_pend) begin
      if (out_ready) begin
        if (m_err && m_cnt < EMAX) m_cnt++;
        m_pend = 0;
      end
    end else if (flush) begin
      mq.delete(); m_sticky = 0;
    end else if (in_valid) begin
      mq.push_back(!(x ^ (a | b)));
      if (y != (a ^ b)) m_sticky = 1;
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) m_data[i] = mq[i];
        m_err = m_sticky; m_pend = 1; m_sticky = 0; mq.delete();
      end
    end
  end

  always @(negedge clk) if (m_known) begin
    chk("in_ready", int'(in_ready), int'(!m_pend && !flush));
    chk("out_valid", int'(out_valid), int'(m_pend));
    chk("out_data", int'(out_data), int'(m_data));
    chk("out_err", int'(out_err), int'(m_err));
    chk("err_cnt", int'(err_cnt), m_cnt);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic word(input logic [W-1:0] v, input bit ab, input int bad);
    for (int i = 0; i < W; i++) begin
      a = ab; b = 0; x = v[i]; y = ab ^ (i == bad); in_valid = 1; out_ready = 0; flush = 0;
      tick();
    end
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1; in_valid = 0; flush = 0; tick(); out_ready = 0;
  endtask

  initial begin
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      {flush, in_valid, a, b, x, y, out_ready} = 7'($urandom);
      tick();
    end
    flush = 0;
    #1;
    chk("T1 out_valid", int'(out_valid), 0);
    chk("T1 out_data", int'(out_data), 0);
    chk("T1 out_err", int'(out_err), 0);
    chk("T1 err_cnt", int'(err_cnt), 0);
    chk("T1 in_ready", int'(in_ready), 1);
    rst_n = 1; in_valid = 0; out_ready = 0;
    tick();
    word(8'hA5, 1, -1);
    chk("T2 out_valid", int'(out_valid), 1);
    chk("T2 out_data", int'(out_data), 'hA5);
    chk("T2 out_err", int'(out_err), 0);
    drain();
    chk("T2 err_cnt", int'(err_cnt), 0);
    chk("T2 released", int'(out_valid), 0);
    word(8'h0F, 0, -1);
    chk("T3 out_data", int'(out_data), 'hF0);
    chk("T3 out_err", int'(out_err), 0);
    drain();
    word(8'hA5, 1, 3);
    chk("T4 out_data", int'(out_data), 'hA5);
    chk("T4 out_err", int'(out_err), 1);
    drain();
    chk("T4 err_cnt", int'(err_cnt), 1);
    word(8'hA5, 1, -1);
    chk("T4 clean err", int'(out_err), 0);
    drain();
    chk("T4 err_cnt kept", int'(err_cnt), 1);
    word(8'h11, 1, -1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; x = 1; a = 1; y = 1; out_ready = 0;
      #1;
      chk("T5 in_ready", int'(in_ready), 0);
      tick();
      chk("T5 hold valid", int'(out_valid), 1);
      chk("T5 hold data", int'(out_data), 'h11);
    end
    out_ready = 1; in_valid = 1; x = 1;
    tick();
    out_ready = 0;
    word(8'h96, 1, -1);
    chk("T5 next word", int'(out_data), 'h96);
    drain();
    for (int i = 0; i < 3; i++) begin
      a = 1; b = 0; y = 1; x = 1; in_valid = 1; tick();
    end
    flush = 1; x = 0; tick(); flush = 0;
    word(8'h3C, 1, -1);
    chk("T6 out_data", int'(out_data), 'h3C);
    for (int i = 0; i < 3; i++) begin
      flush = 1; in_valid = 1; out_ready = 0; tick();
    end
    flush = 0;
    chk("T6 hold flush valid", int'(out_valid), 1);
    chk("T6 hold flush data", int'(out_data), 'h3C);
    drain();
    for (int i = 0; i < 5; i++) begin
      word(8'($urandom), 1, 0);
      drain();
    end
    chk("T6 saturate", int'(err_cnt), EMAX);
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      a = 1'($urandom); b = 1'($urandom); x = 1'($urandom);
      y = (a ^ b) ^ ($urandom_range(0, 29) == 0);
      tick();
    end
    rst_n = 1; flush = 0; in_valid = 0; out_ready = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
